// File: rtl/mem1_if.sv
// rtl/mem1_if.sv - data-memory request/response bus between mem1 and the data memory
interface mem1_if #(
  parameter int RegW = 32
);
  logic [RegW-1:0] dm_addr_o;
  logic [RegW-1:0] dm_wdata_o;
  logic [3:0]      dm_be_n_o;
  logic            dm_re_o;
  logic            dm_we_o;
  logic [RegW-1:0] dm_rdata_i;
  logic            dm_ready_i;

  modport master (
    output dm_addr_o, dm_wdata_o, dm_be_n_o, dm_re_o, dm_we_o,
    input  dm_rdata_i, dm_ready_i
  );

  modport slave (
    input  dm_addr_o, dm_wdata_o, dm_be_n_o, dm_re_o, dm_we_o,
    output dm_rdata_i, dm_ready_i
  );
endinterface

// File: rtl/mem1.sv
// rtl/mem1.sv - first memory-access stage: latches EXE output, issues aligned data-memory requests
module mem1 #(
  parameter int RegW       = 32,
  parameter int WAIT_LIMIT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exe_valid_i,
  output logic            mem1_allowin_o,
  input  logic [5:0]      mem_control_i,
  input  logic [RegW-1:0] exe_result_i,
  input  logic [RegW-1:0] store_data_i,
  input  logic [4:0]      wb_wdest_i,
  input  logic            wb_we_i,
  input  logic [RegW-1:0] pc_i,
  input  logic            mem2_allowin_i,
  output logic            mem1_valid_o,
  output logic [5:0]      mem_control_o,
  output logic [RegW-1:0] exe_result_o,
  output logic [4:0]      wb_wdest_o,
  output logic            wb_we_o,
  output logic [RegW-1:0] pc_o,
  output logic [RegW-1:0] dm_rdata_o,
  output logic            ale_o,
  output logic            bus_err_o,
  output logic [4:0]      ctl_mem1_dest_o,
  mem1_if.master          dm
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            valid_q, ale_q, bus_err_q;
  logic [5:0]      mc_q;
  logic [RegW-1:0] res_q, pc_q, rdata_q;
  logic [4:0]      wdest_q;
  logic            wbwe_q;
  logic [RegW-1:0] addr_q, wdata_q;
  logic [3:0]      be_n_q;
  logic            re_q, we_q;

  logic            accept_w, is_load_w, is_store_w, mem_op_w, aligned_w;
  logic [2:0]      size_w;
  logic [3:0]      be_n_d;
  logic [RegW-1:0] wdata_d;

  assign mem1_allowin_o = (state_q == IDLE) | ((state_q == HOLD) & mem2_allowin_i);
  assign accept_w       = exe_valid_i & mem1_allowin_o;
  assign is_load_w      = mem_control_i[5];
  assign is_store_w     = mem_control_i[4];
  assign size_w         = mem_control_i[2:0];
  assign mem_op_w       = is_load_w | is_store_w;

  // Request shape is computed from the incoming fields and registered on accept.
  always_comb begin
    aligned_w = 1'b1;
    be_n_d    = 4'b0000;
    wdata_d   = '0;
    case (size_w)
      3'd4:    aligned_w = 1'b1;
      3'd2:    aligned_w = ~exe_result_i[0];
      default: aligned_w = (exe_result_i[1:0] == 2'b00);
    endcase
    if (is_store_w) begin
      case (size_w)
        3'd4: begin
          be_n_d  = ~(4'b0001 << exe_result_i[1:0]);
          wdata_d = {4{store_data_i[7:0]}};
        end
        3'd2: begin
          be_n_d  = exe_result_i[1] ? 4'b0011 : 4'b1100;
          wdata_d = {2{store_data_i[15:0]}};
        end
        default: begin
          be_n_d  = 4'b0000;
          wdata_d = store_data_i;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      ale_q     <= 1'b0;
      bus_err_q <= 1'b0;
      mc_q      <= '0;
      res_q     <= '0;
      pc_q      <= '0;
      rdata_q   <= '0;
      wdest_q   <= '0;
      wbwe_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_n_q    <= 4'hF;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
    end else if (accept_w) begin
      mc_q      <= mem_control_i;
      res_q     <= exe_result_i;
      pc_q      <= pc_i;
      wdest_q   <= wb_wdest_i;
      wbwe_q    <= wb_we_i;
      ale_q     <= mem_op_w & ~aligned_w;
      bus_err_q <= 1'b0;
      cnt_q     <= '0;
      if (mem_op_w & aligned_w) begin
        state_q <= BUSY;
        valid_q <= 1'b0;
        re_q    <= is_load_w;
        we_q    <= is_store_w;
        addr_q  <= {exe_result_i[RegW-1:2], 2'b00};
        be_n_q  <= be_n_d;
        wdata_q <= wdata_d;
      end else begin
        state_q <= HOLD;
        valid_q <= 1'b1;
      end
    end else begin
      case (state_q)
        BUSY: begin
          // Completion or timeout both retire the request and move to HOLD.
          if (dm.dm_ready_i || (cnt_q == LIMIT_M1)) begin
            state_q <= HOLD;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_n_q  <= 4'hF;
            if (dm.dm_ready_i && mc_q[5]) rdata_q <= dm.dm_rdata_i;
            if (!dm.dm_ready_i) bus_err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (mem2_allowin_i) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            ale_q     <= 1'b0;
            bus_err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem1_valid_o    = valid_q;
  assign mem_control_o   = mc_q;
  assign exe_result_o    = res_q;
  assign wb_wdest_o      = wdest_q;
  assign wb_we_o         = wbwe_q;
  assign pc_o            = pc_q;
  assign dm_rdata_o      = rdata_q;
  assign ale_o           = ale_q;
  assign bus_err_o       = bus_err_q;
  assign ctl_mem1_dest_o = wdest_q & {5{state_q != IDLE}};
  assign dm.dm_addr_o    = addr_q;
  assign dm.dm_wdata_o   = wdata_q;
  assign dm.dm_be_n_o    = be_n_q;
  assign dm.dm_re_o      = re_q;
  assign dm.dm_we_o      = we_q;

endmodule

// File: tb/tb_mem1.sv
// tb/tb_mem1.sv - scoreboard bench for mem1 (WAIT_LIMIT=4)
module tb_mem1;
  logic        clk = 1'b0;
  logic        rst;
  logic        exe_valid_i, mem1_allowin_o;
  logic [5:0]  mem_control_i, mem_control_o;
  logic [31:0] exe_result_i, store_data_i, pc_i;
  logic [4:0]  wb_wdest_i, wb_wdest_o, ctl_mem1_dest_o;
  logic        wb_we_i, wb_we_o, mem2_allowin_i, mem1_valid_o;
  logic [31:0] exe_result_o, pc_o, dm_rdata_o;
  logic        ale_o, bus_err_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  mem1_if dm ();

  mem1 #(.RegW(32), .WAIT_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .exe_valid_i(exe_valid_i), .mem1_allowin_o(mem1_allowin_o),
    .mem_control_i(mem_control_i), .exe_result_i(exe_result_i),
    .store_data_i(store_data_i), .wb_wdest_i(wb_wdest_i), .wb_we_i(wb_we_i),
    .pc_i(pc_i), .mem2_allowin_i(mem2_allowin_i), .mem1_valid_o(mem1_valid_o),
    .mem_control_o(mem_control_o), .exe_result_o(exe_result_o),
    .wb_wdest_o(wb_wdest_o), .wb_we_o(wb_we_o), .pc_o(pc_o),
    .dm_rdata_o(dm_rdata_o), .ale_o(ale_o), .bus_err_o(bus_err_o),
    .ctl_mem1_dest_o(ctl_mem1_dest_o), .dm(dm)
  );

  always #5 clk = ~clk;

  task automatic drive_op(input logic [5:0] ctl, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [31:0] pc, input logic [4:0] dest);
    exe_valid_i   = 1'b1;
    mem_control_i = ctl;
    exe_result_i  = addr;
    store_data_i  = sd;
    pc_i          = pc;
    wb_wdest_i    = dest;
    wb_we_i       = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; exe_valid_i = 1'b0; mem_control_i = '0; exe_result_i = '0;
    store_data_i = '0; pc_i = '0; wb_wdest_i = '0; wb_we_i = 1'b0;
    mem2_allowin_i = 1'b1; dm.dm_rdata_i = '0; dm.dm_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem1_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", mem1_valid_o); end
    n_cmp++; if (mem1_allowin_o !== 1'b1) begin n_err++; $display("FAIL rst_allowin got=%b exp=1", mem1_allowin_o); end
    n_cmp++; if (dm.dm_be_n_o !== 4'hF) begin n_err++; $display("FAIL rst_be_n got=%h exp=f", dm.dm_be_n_o); end
    n_cmp++; if ({dm.dm_re_o, dm.dm_we_o, ale_o, bus_err_o} !== 4'b0) begin n_err++; $display("FAIL rst_flags got=%b exp=0000", {dm.dm_re_o, dm.dm_we_o, ale_o, bus_err_o}); end
    n_cmp++; if ({dm.dm_addr_o, ctl_mem1_dest_o} !== 37'b0) begin n_err++; $display("FAIL rst_addr_dest got=%h exp=0", {dm.dm_addr_o, ctl_mem1_dest_o}); end
    rst = 1'b0;
  endtask

  task automatic test_store_byte();
    @(negedge clk);
    mem2_allowin_i = 1'b0;
    drive_op(6'b010100, 32'h0000_1003, 32'h0000_00AB, 32'h100, 5'd3);
    #1;
    if (exe_valid_i && mem1_allowin_o) exp_q.push_back(32'h100);
    @(negedge clk);
    exe_valid_i = 1'b0; dm.dm_ready_i = 1'b1;
    #1;
    n_cmp++; if (dm.dm_we_o !== 1'b1) begin n_err++; $display("FAIL sb_we got=%b exp=1", dm.dm_we_o); end
    n_cmp++; if (dm.dm_addr_o !== 32'h0000_1000) begin n_err++; $display("FAIL sb_addr got=%h exp=00001000", dm.dm_addr_o); end
    n_cmp++; if (dm.dm_be_n_o !== 4'b0111) begin n_err++; $display("FAIL sb_be_n got=%b exp=0111", dm.dm_be_n_o); end
    n_cmp++; if (dm.dm_wdata_o !== 32'hABAB_ABAB) begin n_err++; $display("FAIL sb_wdata got=%h exp=abababab", dm.dm_wdata_o); end
    n_cmp++; if (ctl_mem1_dest_o !== 5'd3) begin n_err++; $display("FAIL sb_dest got=%0d exp=3", ctl_mem1_dest_o); end
    @(negedge clk);
    dm.dm_ready_i = 1'b0; mem2_allowin_i = 1'b1;
    #1;
    n_cmp++; if ({mem1_valid_o, dm.dm_we_o, dm.dm_be_n_o} !== 6'b10_1111) begin n_err++; $display("FAIL sb_hold got=%b exp=101111", {mem1_valid_o, dm.dm_we_o, dm.dm_be_n_o}); end
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    n_cmp++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL sb_pc got=%h exp=%h", pc_o, exp_pc); end
    @(negedge clk);
    #1;
    n_cmp++; if ({mem1_valid_o, ctl_mem1_dest_o} !== 6'b0) begin n_err++; $display("FAIL sb_idle got=%b exp=0", {mem1_valid_o, ctl_mem1_dest_o}); end
  endtask

  task automatic test_store_half();
    drive_op(6'b010010, 32'h0000_7002, 32'h0000_BEEF, 32'h700, 5'd7);
    #1;
    if (exe_valid_i && mem1_allowin_o) exp_q.push_back(32'h700);
    @(negedge clk);
    exe_valid_i = 1'b0; dm.dm_ready_i = 1'b1;
    #1;
    n_cmp++; if (dm.dm_be_n_o !== 4'b0011) begin n_err++; $display("FAIL sh_be_n got=%b exp=0011", dm.dm_be_n_o); end
    n_cmp++; if (dm.dm_wdata_o !== 32'hBEEF_BEEF) begin n_err++; $display("FAIL sh_wdata got=%h exp=beefbeef", dm.dm_wdata_o); end
    @(negedge clk);
    dm.dm_ready_i = 1'b0;
    #1;
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    n_cmp++; if (!mem1_valid_o || pc_o !== exp_pc) begin n_err++; $display("FAIL sh_out got=%b/%h exp=1/%h", mem1_valid_o, pc_o, exp_pc); end
    @(negedge clk);
  endtask

  task automatic test_load_half();
    mem2_allowin_i = 1'b0;
    drive_op(6'b101010, 32'h0000_2002, 32'h0, 32'h200, 5'd9);
    #1;
    if (exe_valid_i && mem1_allowin_o) exp_q.push_back(32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exe_valid_i = 1'b0;
      dm.dm_ready_i = (i == 2);
      dm.dm_rdata_i = (i == 2) ? 32'h8001_1234 : 32'hDEAD_0000;
      #1;
      n_cmp++; if ({dm.dm_re_o, dm.dm_be_n_o, mem1_allowin_o, mem1_valid_o} !== 7'b1_0000_00) begin n_err++; $display("FAIL lh_busy%0d got=%b exp=1000000", i, {dm.dm_re_o, dm.dm_be_n_o, mem1_allowin_o, mem1_valid_o}); end
      n_cmp++; if (dm.dm_addr_o !== 32'h0000_2000) begin n_err++; $display("FAIL lh_addr%0d got=%h exp=00002000", i, dm.dm_addr_o); end
    end
    @(negedge clk);
    dm.dm_ready_i = 1'b0; dm.dm_rdata_i = '0;
    #1;
    n_cmp++; if (dm_rdata_o !== 32'h8001_1234) begin n_err++; $display("FAIL lh_rdata got=%h exp=80011234", dm_rdata_o); end
    n_cmp++; if ({mem1_valid_o, dm.dm_re_o} !== 2'b10) begin n_err++; $display("FAIL lh_hold got=%b exp=10", {mem1_valid_o, dm.dm_re_o}); end
    @(negedge clk);
    #1;
    n_cmp++; if (dm_rdata_o !== 32'h8001_1234) begin n_err++; $display("FAIL lh_stable got=%h exp=80011234", dm_rdata_o); end
    mem2_allowin_i = 1'b1;
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    n_cmp++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL lh_pc got=%h exp=%h", pc_o, exp_pc); end
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    drive_op(6'b010001, 32'h0000_3001, 32'h1111_2222, 32'h300, 5'd4);
    #1;
    if (exe_valid_i && mem1_allowin_o) exp_q.push_back(32'h300);
    @(negedge clk);
    exe_valid_i = 1'b0;
    #1;
    n_cmp++; if ({dm.dm_we_o, ale_o, mem1_valid_o} !== 3'b011) begin n_err++; $display("FAIL mis_flags got=%b exp=011", {dm.dm_we_o, ale_o, mem1_valid_o}); end
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    n_cmp++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL mis_pc got=%h exp=%h", pc_o, exp_pc); end
    @(negedge clk);
    #1;
    n_cmp++; if ({ale_o, mem1_valid_o} !== 2'b00) begin n_err++; $display("FAIL mis_clear got=%b exp=00", {ale_o, mem1_valid_o}); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat;
    int idx, xfers;
    pat = 5'b11001;
    idx = 0; xfers = 0;
    for (int cyc = 0; cyc < 30 && xfers < 4; cyc++) begin
      mem2_allowin_i = (cyc < 5) ? pat[4 - cyc] : 1'b1;
      exe_valid_i = (idx < 4);
      mem_control_i = '0;
      exe_result_i = 32'h40 + idx;
      pc_i = 32'h400 + 32'(idx * 4);
      wb_wdest_i = 5'(idx + 1);
      #1;
      if (mem1_valid_o) begin
        exp_pc = (exp_q.size() > 0) ? exp_q[0] : 32'hFFFF_FFFF;
        n_cmp++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL b2b_pc cyc%0d got=%h exp=%h", cyc, pc_o, exp_pc); end
        if (mem2_allowin_i) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          xfers++;
        end
      end
      if (exe_valid_i && mem1_allowin_o) begin
        exp_q.push_back(pc_i);
        idx++;
      end
      @(negedge clk);
    end
    exe_valid_i = 1'b0;
    n_cmp++; if (xfers !== 4 || exp_q.size() != 0) begin n_err++; $display("FAIL b2b_count got=%0d left=%0d exp=4/0", xfers, exp_q.size()); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    mem2_allowin_i = 1'b0; dm.dm_ready_i = 1'b0;
    drive_op(6'b100001, 32'h0000_5000, 32'h0, 32'h500, 5'd5);
    #1;
    if (exe_valid_i && mem1_allowin_o) exp_q.push_back(32'h500);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exe_valid_i = 1'b0;
      #1;
      n_cmp++; if ({dm.dm_re_o, bus_err_o, mem1_valid_o} !== 3'b100) begin n_err++; $display("FAIL to_busy%0d got=%b exp=100", i, {dm.dm_re_o, bus_err_o, mem1_valid_o}); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if ({bus_err_o, dm.dm_re_o, mem1_valid_o, dm.dm_be_n_o} !== 7'b101_1111) begin n_err++; $display("FAIL to_abort got=%b exp=1011111", {bus_err_o, dm.dm_re_o, mem1_valid_o, dm.dm_be_n_o}); end
    mem2_allowin_i = 1'b1;
    exp_pc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    n_cmp++; if (pc_o !== exp_pc) begin n_err++; $display("FAIL to_pc got=%h exp=%h", pc_o, exp_pc); end
    @(negedge clk);
    #1;
    n_cmp++; if ({bus_err_o, mem1_valid_o} !== 2'b00) begin n_err++; $display("FAIL to_clear got=%b exp=00", {bus_err_o, mem1_valid_o}); end
  endtask

  task automatic test_reset_busy();
    drive_op(6'b010001, 32'h0000_6000, 32'h1234_5678, 32'h600, 5'd6);
    @(negedge clk);
    exe_valid_i = 1'b0;
    #1;
    n_cmp++; if ({dm.dm_we_o, dm.dm_be_n_o} !== 5'b1_0000) begin n_err++; $display("FAIL rb_we got=%b exp=10000", {dm.dm_we_o, dm.dm_be_n_o}); end
    n_cmp++; if (dm.dm_wdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL rb_wdata got=%h exp=12345678", dm.dm_wdata_o); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++; if ({dm.dm_we_o, dm.dm_be_n_o, mem1_valid_o, mem1_allowin_o} !== 7'b0_1111_01) begin n_err++; $display("FAIL rb_after got=%b exp=0111101", {dm.dm_we_o, dm.dm_be_n_o, mem1_valid_o, mem1_allowin_o}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half();
    test_load_half();
    test_misaligned();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
